cpu_divider: RTL and testbench

- Iterative 32-bit divide/remainder unit for the RV32M DIV, DIVU, REM and REMU instructions.
- Sits in the execute stage beside the combinational ALU. It takes the same operand_a/operand_b operands when decode selects a divide opcode.
- The control unit stalls the pipeline while the divider is busy, then writes back its result in place of the ALU result.

---
 rtl/cpu_divider.sv | 167 ++++++++++++++++
 tb/tb_cpu_divider.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_divider.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Optional early-out for divide-by-zero/overflow: CPU_DIVIDER_EARLY_OUT_EN.
module cpu_divider #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic            flush,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_q, state_d;
  logic [5:0]      count_q, count_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quot_q, quot_d;
  logic [XLEN-1:0] dvsr_q, dvsr_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [1:0]      op_q, op_d;
  logic            negq_q, negq_d;
  logic            negr_q, negr_d;
  logic            dz_q, dz_d;
  logic            ovf_q, ovf_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            early;
  logic            sgn;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] mag_a, mag_b;
  logic [XLEN:0]   rem_sh;
  logic            ge;
  logic [XLEN-1:0] diff;
  logic [XLEN-1:0] q_fin, r_fin, fin;

`ifdef CPU_DIVIDER_EARLY_OUT_EN
  assign early = dz_q | ovf_q;
`else
  assign early = 1'b0;
`endif

  // Next-state, datapath step and result selection.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    rem_d    = rem_q;
    quot_d   = quot_q;
    dvsr_d   = dvsr_q;
    a_d      = a_q;
    op_d     = op_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    dz_d     = dz_q;
    ovf_d    = ovf_q;
    result_d = result_q;

    sgn   = ~op[0];
    a_neg = sgn & operand_a[XLEN-1];
    b_neg = sgn & operand_b[XLEN-1];
    mag_a = a_neg ? -operand_a : operand_a;
    mag_b = b_neg ? -operand_b : operand_b;

    rem_sh = {rem_q, quot_q[XLEN-1]};
    ge     = rem_sh >= {1'b0, dvsr_q};
    diff   = rem_sh[XLEN-1:0] - dvsr_q;

    q_fin = negq_q ? -quot_q : quot_q;
    r_fin = (negr_q && |rem_q) ? -rem_q : rem_q;
    if (dz_q)
      fin = op_q[1] ? a_q : '1;
    else if (ovf_q)
      fin = op_q[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    else
      fin = op_q[1] ? r_fin : q_fin;

    unique case (state_q)
      IDLE: begin
        if (!flush && start) begin
          state_d = CALC;
          count_d = '0;
          rem_d   = '0;
          quot_d  = mag_a;
          dvsr_d  = mag_b;
          a_d     = operand_a;
          op_d    = op;
          negq_d  = a_neg ^ b_neg;
          negr_d  = a_neg;
          dz_d    = ~|operand_b;
          ovf_d   = sgn
                  & (operand_a == {1'b1, {(XLEN-1){1'b0}}})
                  & (&operand_b);
        end
      end
      CALC: begin
        if (flush) begin
          state_d = IDLE;
        end else if (count_q == 6'd32 || early) begin
          result_d = fin;
          state_d  = DONE;
        end else begin
          rem_d   = ge ? diff : rem_sh[XLEN-1:0];
          quot_d  = {quot_q[XLEN-2:0], ge};
          count_d = count_q + 6'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
  end

  // State and registered outputs; rst wins over flush and start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
      dvsr_q   <= '0;
      a_q      <= '0;
      op_q     <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rem_q    <= rem_d;
      quot_q   <= quot_d;
      dvsr_q   <= dvsr_d;
      a_q      <= a_d;
      op_q     <= op_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      dz_q     <= dz_d;
      ovf_q    <= ovf_d;
      result_q <= result_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign ready  = ready_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_cpu_divider.sv
// Scoreboard bench for cpu_divider: random and directed ops
// checked against an arithmetic reference model.
module tb_cpu_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic        flush = 1'b0;
  logic        ready, busy, done;
  logic [31:0] result;

  cpu_divider #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b),
    .flush(flush), .ready(ready), .busy(busy),
    .done(done), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] last_exp = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] model(
    input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb_, q, r;
    if (b == 0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0]) begin
      sa = $signed(a);
      sb_ = $signed(b);
    end else begin
      sa = {32'b0, a};
      sb_ = {32'b0, b};
    end
    q = sa / sb_;
    r = sa % sb_;
    return o[1] ? r[31:0] : q[31:0];
  endfunction

  function automatic int lat(
    input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
`ifdef CPU_DIVIDER_EARLY_OUT_EN
    if (b == 0) return 2;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
`endif
    return 34;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pop and compare whenever the DUT signals done.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done at cycle %0d expected none",
                 cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        last_exp = e.res;
        chk("result", result, e.res);
        chk("latency", cyc, e.cyc);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!ready) begin
      failures++;
      $display("FAIL ready_timeout: got ready=%b expected 1", ready);
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input bit push);
    wait_ready();
    op = o;
    operand_a = a;
    operand_b = b;
    start = 1'b1;
    if (push) sb.push_back('{model(o, a, b), cyc + lat(o, a, b)});
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  function automatic logic [31:0] pick();
    int unsigned r;
    r = $urandom_range(0, 9);
    case (r)
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_ready", {31'b0, ready}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_result", result, 32'd0);

    issue(2'b01, 32'd100, 32'd7, 1);
    issue(2'b11, 32'd100, 32'd7, 1);
    issue(2'b00, 32'hFFFF_FF9C, 32'd7, 1);
    issue(2'b10, 32'hFFFF_FF9C, 32'd7, 1);
    issue(2'b10, 32'd100, 32'hFFFF_FFF9, 1);
    issue(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    issue(2'b01, 32'd5, 32'd0, 1);
    issue(2'b10, 32'd5, 32'd0, 1);
    issue(2'b00, 32'hFFFF_FFF6, 32'd0, 1);
    drain();

    // start held high during CALC with new operands
    wait_ready();
    op = 2'b01; operand_a = 32'd100; operand_b = 32'd7; start = 1'b1;
    sb.push_back('{model(2'b01, 32'd100, 32'd7), cyc + 34});
    @(posedge clk); #1;
    op = 2'b11; operand_a = 32'd1000; operand_b = 32'd3;
    begin
      int n = 0;
      do begin
        @(posedge clk); #1;
        n++;
      end while (!ready && n < 100);
    end
    sb.push_back('{model(2'b11, 32'd1000, 32'd3), cyc + 34});
    @(posedge clk); #1;
    start = 1'b0;
    drain();

    // flush at iteration 10
    issue(2'b01, 32'd12345, 32'd17, 0);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_ready", {31'b0, ready}, 32'd1);
    chk("flush_busy", {31'b0, busy}, 32'd0);
    chk("flush_result", result, last_exp);
    repeat (40) @(posedge clk);
    #1;

    // flush beats start in IDLE
    op = 2'b01; operand_a = 32'd9; operand_b = 32'd2;
    start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("idle_flush_ready", {31'b0, ready}, 32'd1);
    chk("idle_flush_busy", {31'b0, busy}, 32'd0);
    repeat (40) @(posedge clk);
    #1;

    // rst mid-CALC
    issue(2'b00, 32'd777, 32'd5, 0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    last_exp = '0;
    chk("midrst_ready", {31'b0, ready}, 32'd1);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_result", result, 32'd0);
    repeat (40) @(posedge clk);
    #1;

    for (int i = 0; i < 1500; i++) begin
      logic [1:0]  o;
      logic [31:0] a, b;
      o = 2'($urandom_range(0, 3));
      a = pick();
      b = pick();
      issue(o, a, b, 1);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
